// File: rtl/reg_dump_ctrl.sv
`timescale 1ns/1ps
// Purpose: runs a processor for NUM_CYCLES cycles, freezes its regfile, then streams every register out.
// Latency: CLR 1 cycle, RUN NUM_CYCLES cycles, then 2 cycles per dumped word (SETTLE + DUMP).
// Backpressure: dump_ready low holds the current dump word stable indefinitely; regfile stays frozen.
module reg_dump_ctrl #(
  parameter int NUM_CYCLES = 500,
  parameter int NUM_REGS   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        cpu_reset,
  input  logic        proc_rwe,
  output logic        rf_we,
  input  logic [4:0]  proc_rs1,
  output logic [4:0]  rf_rs1,
  input  logic [31:0] rf_dataA,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_index,
  output logic [31:0] dump_data,
  output logic [15:0] cycle_count,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DUMP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [15:0] LAST_CYCLE = 16'(NUM_CYCLES - 1);
  localparam logic [4:0]  LAST_REG   = 5'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [15:0] cycle_count_q, cycle_count_d;
  logic [4:0]  dump_index_q, dump_index_d;
  logic [31:0] dump_data_q, dump_data_d;
  logic        dump_valid_q, dump_valid_d;
  logic        done_q, done_d;
  logic        cpu_reset_q, cpu_reset_d;

  // Next-state and next-output computation for the run/dump sequencer
  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    dump_index_d  = dump_index_q;
    dump_data_d   = dump_data_q;
    dump_valid_d  = dump_valid_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        cycle_count_d = '0;
        dump_index_d  = '0;
        dump_valid_d  = 1'b0;
        state_d       = RUN;
      end
      RUN: begin
        cycle_count_d = cycle_count_q + 16'd1;
        if (cycle_count_q == LAST_CYCLE) state_d = SETTLE;
      end
      SETTLE: begin
        // rf_rs1 has pointed at dump_index for a full cycle, so rf_dataA is stable here
        dump_data_d  = rf_dataA;
        dump_valid_d = 1'b1;
        state_d      = DUMP;
      end
      DUMP: begin
        if (dump_valid_q && dump_ready) begin
          dump_valid_d = 1'b0;
          if (dump_index_q == LAST_REG) begin
            state_d = DONE;
          end else begin
            dump_index_d = dump_index_q + 5'd1;
            state_d      = SETTLE;
          end
        end
      end
      DONE: begin
        if (start) state_d = CLR;
      end
      default: state_d = IDLE;
    endcase
    done_d      = (state_d == DONE);
    cpu_reset_d = (state_d == IDLE) || (state_d == CLR);
  end

  // State and registered outputs; reset forces the idle/held-in-reset condition at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cycle_count_q <= '0;
      dump_index_q  <= '0;
      dump_data_q   <= '0;
      dump_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      cpu_reset_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      dump_index_q  <= dump_index_d;
      dump_data_q   <= dump_data_d;
      dump_valid_q  <= dump_valid_d;
      done_q        <= done_d;
      cpu_reset_q   <= cpu_reset_d;
    end
  end

  // Regfile access: writes pass only while running, reads steered to the dump pointer while dumping
  always_comb begin
    rf_we  = (state_q == RUN) && proc_rwe;
    rf_rs1 = ((state_q == SETTLE) || (state_q == DUMP)) ? dump_index_q : proc_rs1;
  end

  assign cpu_reset   = cpu_reset_q;
  assign dump_valid  = dump_valid_q;
  assign dump_index  = dump_index_q;
  assign dump_data   = dump_data_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
`timescale 1ns/1ps
// Directed bench for reg_dump_ctrl with NUM_CYCLES=4, NUM_REGS=32.
// Regfile modelled as a read-only table: reg 0 = 0, reg k = 100+k.
// Inputs driven and outputs sampled 1 ns after each rising edge.
module tb_reg_dump_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        cpu_reset;
  logic        proc_rwe;
  logic        rf_we;
  logic [4:0]  proc_rs1;
  logic [4:0]  rf_rs1;
  logic [31:0] rf_dataA;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;
  logic [15:0] cycle_count;
  logic        done;

  int errors = 0;
  int checks = 0;

  reg_dump_ctrl #(.NUM_CYCLES(4), .NUM_REGS(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .cpu_reset   (cpu_reset),
    .proc_rwe    (proc_rwe),
    .rf_we       (rf_we),
    .proc_rs1    (proc_rs1),
    .rf_rs1      (rf_rs1),
    .rf_dataA    (rf_dataA),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_index  (dump_index),
    .dump_data   (dump_data),
    .cycle_count (cycle_count),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Regfile read port model
  always_comb rf_dataA = (rf_rs1 == 5'd0) ? 32'd0 : 32'd100 + 32'(rf_rs1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse start, then walk CLR and the 4 RUN cycles; optionally pulse start mid-RUN
  task automatic do_run(input bit poke_start);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clr_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("clr_rf_we", 32'(rf_we), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
      chk("run_rf_we", 32'(rf_we), 32'd1);
      chk("run_rs1", 32'(rf_rs1), 32'(proc_rs1));
      chk("run_count", 32'(cycle_count), 32'(i));
      start = poke_start && (i == 1);
    end
    start = 1'b0;
    step();
    chk("settle_count", 32'(cycle_count), 32'd4);
    chk("settle_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("settle_rf_we", 32'(rf_we), 32'd0);
  endtask

  int handshakes;

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    proc_rwe   = 1'b1;
    proc_rs1   = 5'd7;
    dump_ready = 1'b1;
    #12;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_index", 32'(dump_index), 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_count", 32'(cycle_count), 32'd0);
    chk("rst_rs1", 32'(rf_rs1), 32'd7);
    reset = 1'b1;
    step();
    step();
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

    // First run with a start poke in RUN, then full dump with a stall at index 5
    do_run(1'b1);
    handshakes = 0;
    for (int k = 0; k < 32; k++) begin
      chk("settle_valid", 32'(dump_valid), 32'd0);
      chk("settle_rs1", 32'(rf_rs1), 32'(k));
      step();
      chk("dump_valid", 32'(dump_valid), 32'd1);
      chk("dump_index", 32'(dump_index), 32'(k));
      chk("dump_data", dump_data, (k == 0) ? 32'd0 : 32'd100 + 32'(k));
      chk("dump_rf_we", 32'(rf_we), 32'd0);
      chk("dump_count", 32'(cycle_count), 32'd4);
      if (k == 5) begin
        dump_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          step();
          chk("stall_valid", 32'(dump_valid), 32'd1);
          chk("stall_index", 32'(dump_index), 32'd5);
          chk("stall_data", dump_data, 32'd105);
        end
        dump_ready = 1'b1;
      end
      if (dump_valid && dump_ready) handshakes++;
      step();
    end
    chk("handshakes", 32'(handshakes), 32'd32);
    chk("done_set", 32'(done), 32'd1);
    chk("done_valid", 32'(dump_valid), 32'd0);
    chk("done_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("done_rs1", 32'(rf_rs1), 32'd7);
    chk("done_count", 32'(cycle_count), 32'd4);
    step();
    step();
    chk("done_hold", 32'(done), 32'd1);

    // Restart from DONE, then abort with reset in the middle of the dump
    proc_rs1 = 5'd3;
    do_run(1'b0);
    for (int k = 0; k < 12; k++) begin
      step();
      step();
    end
    step();
    chk("pre_abort_index", 32'(dump_index), 32'd12);
    chk("pre_abort_valid", 32'(dump_valid), 32'd1);
    chk("pre_abort_data", dump_data, 32'd112);
    reset = 1'b0;
    #0.5;
    chk("abort_valid", 32'(dump_valid), 32'd0);
    chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("abort_index", 32'(dump_index), 32'd0);
    chk("abort_data", dump_data, 32'd0);
    #0.5;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_abort_valid", 32'(dump_valid), 32'd0);
      chk("post_abort_cpu_reset", 32'(cpu_reset), 32'd1);
    end

    // Fresh run after abort starts dumping from index 0
    do_run(1'b0);
    step();
    chk("fresh_index0", 32'(dump_index), 32'd0);
    chk("fresh_data0", dump_data, 32'd0);
    step();
    step();
    chk("fresh_index1", 32'(dump_index), 32'd1);
    chk("fresh_data1", dump_data, 32'd101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
